// File: rtl/dsp_simd_alu.sv
// Two-stage SIMD ALU: independent WIDTH-bit lanes doing ADD/SUB/ACC/CLR.
// S1 registers operands, S2 registers results; a single enable stalls both stages.
module dsp_simd_alu #(
    parameter int WIDTH = 12,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               op_i,
    input  logic [LANES*WIDTH-1:0]   a_i,
    input  logic [LANES*WIDTH-1:0]   b_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LANES*WIDTH-1:0]   y_o,
    output logic [LANES-1:0]         carry_o
);

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpAcc = 2'd2,
        OpClr = 2'd3
    } op_e;

    logic                   en;
    logic                   s1Valid_q;
    op_e                    s1Op_q;
    logic [LANES*WIDTH-1:0] s1A_q;
    logic [LANES*WIDTH-1:0] s1B_q;
    logic                   s2Valid_q;
    logic [LANES*WIDTH-1:0] y_q;
    logic [LANES-1:0]       carry_q;
    logic [LANES*WIDTH-1:0] acc_q;

    logic [LANES*WIDTH-1:0] y_d;
    logic [LANES-1:0]       carry_d;
    logic [LANES*WIDTH-1:0] acc_d;
    logic [WIDTH:0]         laneSum;

    assign en          = !s2Valid_q || out_ready_i;
    assign in_ready_o  = en;
    assign out_valid_o = s2Valid_q;
    assign y_o         = y_q;
    assign carry_o     = carry_q;

    // Each lane works on a WIDTH+1 bit sum so the top bit is that lane's carry/borrow.
    always_comb begin
        y_d     = '0;
        carry_d = '0;
        acc_d   = acc_q;
        laneSum = '0;
        for (int i = 0; i < LANES; i++) begin
            case (s1Op_q)
                OpAdd: laneSum = {1'b0, s1A_q[i*WIDTH +: WIDTH]} + {1'b0, s1B_q[i*WIDTH +: WIDTH]};
                OpSub: laneSum = {1'b0, s1A_q[i*WIDTH +: WIDTH]} - {1'b0, s1B_q[i*WIDTH +: WIDTH]};
                OpAcc: begin
                    laneSum = {1'b0, acc_q[i*WIDTH +: WIDTH]} + {1'b0, s1A_q[i*WIDTH +: WIDTH]};
                    acc_d[i*WIDTH +: WIDTH] = laneSum[WIDTH-1:0];
                end
                default: begin
                    laneSum = '0;
                    acc_d[i*WIDTH +: WIDTH] = '0;
                end
            endcase
            y_d[i*WIDTH +: WIDTH] = laneSum[WIDTH-1:0];
            carry_d[i]            = laneSum[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Op_q    <= OpAdd;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s2Valid_q <= 1'b0;
            y_q       <= '0;
            carry_q   <= '0;
            acc_q     <= '0;
        end else if (en) begin
            s1Valid_q <= in_valid_i;
            s1Op_q    <= op_e'(op_i);
            s1A_q     <= a_i;
            s1B_q     <= b_i;
            s2Valid_q <= s1Valid_q;
            // Bubbles leave the previous result and the accumulators untouched.
            if (s1Valid_q) begin
                y_q     <= y_d;
                carry_q <= carry_d;
                acc_q   <= acc_d;
            end
        end
    end

endmodule

// File: tb/tb_dsp_simd_alu.sv
// Scoreboard bench for dsp_simd_alu across four WIDTH/LANES configurations.
// Stimulus pushes expected results; a negedge monitor pops them on each output handshake.
module tb_dsp_simd_alu;

    typedef struct packed {
        logic [47:0] y;
        logic [3:0]  c;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  inValid;
    logic [3:0]  outReady;
    logic [3:0]  inReady;
    logic [3:0]  outValid;
    logic [1:0]  opS [4];
    logic [47:0] aS  [4];
    logic [47:0] bS  [4];
    logic [47:0] yBus [4];
    logic [3:0]  cBus [4];

    logic [7:0]  y0;
    logic [0:0]  c0;
    logic [47:0] y1;
    logic [3:0]  c1;
    logic [47:0] y2;
    logic [1:0]  c2;
    logic [11:0] y3;
    logic [0:0]  c3;

    expT q0[$];
    expT q1[$];
    expT q2[$];
    expT q3[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_simd_alu #(.WIDTH(8), .LANES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(inValid[0]), .in_ready_o(inReady[0]),
        .op_i(opS[0]), .a_i(aS[0][7:0]), .b_i(bS[0][7:0]), .out_valid_o(outValid[0]),
        .out_ready_i(outReady[0]), .y_o(y0), .carry_o(c0));

    dsp_simd_alu #(.WIDTH(12), .LANES(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(inValid[1]), .in_ready_o(inReady[1]),
        .op_i(opS[1]), .a_i(aS[1]), .b_i(bS[1]), .out_valid_o(outValid[1]),
        .out_ready_i(outReady[1]), .y_o(y1), .carry_o(c1));

    dsp_simd_alu #(.WIDTH(24), .LANES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(inValid[2]), .in_ready_o(inReady[2]),
        .op_i(opS[2]), .a_i(aS[2]), .b_i(bS[2]), .out_valid_o(outValid[2]),
        .out_ready_i(outReady[2]), .y_o(y2), .carry_o(c2));

    dsp_simd_alu #(.WIDTH(12), .LANES(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(inValid[3]), .in_ready_o(inReady[3]),
        .op_i(opS[3]), .a_i(aS[3][11:0]), .b_i(bS[3][11:0]), .out_valid_o(outValid[3]),
        .out_ready_i(outReady[3]), .y_o(y3), .carry_o(c3));

    assign yBus[0] = {40'b0, y0};
    assign yBus[1] = y1;
    assign yBus[2] = y2;
    assign yBus[3] = {36'b0, y3};
    assign cBus[0] = {3'b0, c0};
    assign cBus[1] = c1;
    assign cBus[2] = {2'b0, c2};
    assign cBus[3] = {3'b0, c3};

    function automatic void pushExp(input int k, input expT e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    function automatic int qSize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic popExp(input int k, output bit ok, output expT e);
        ok = (qSize(k) != 0);
        e  = '0;
        if (ok) begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Enter at posedge+1; leaves at posedge+1 just after the accepting edge.
    task automatic applyStimulus(input int k, input logic [1:0] op, input logic [47:0] a,
                                 input logic [47:0] b, input logic [47:0] ey, input logic [3:0] ec);
        bit accepted = 1'b0;
        inValid[k] = 1'b1;
        opS[k] = op;
        aS[k] = a;
        bS[k] = b;
        for (int t = 0; t < 20 && !accepted; t++) begin
            @(negedge clk);
            if (inReady[k]) begin
                pushExp(k, '{y: ey, c: ec});
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        inValid[k] = 1'b0;
        if (!accepted) checkOutput($sformatf("accept timeout dut%0d", k), 48'd0, 48'd1);
    endtask

    task automatic drain(input int k);
        for (int t = 0; t < 50 && qSize(k) != 0; t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("drain dut%0d leftover", k), 48'(qSize(k)), 48'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (outValid[k] && outReady[k]) begin
                    bit  ok;
                    expT e;
                    popExp(k, ok, e);
                    if (!ok) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected output dut%0d: got y=%h, expected none", k, yBus[k]);
                    end else begin
                        checkOutput($sformatf("y dut%0d", k), yBus[k], e.y);
                        checkOutput($sformatf("carry dut%0d", k), {44'b0, cBus[k]}, {44'b0, e.c});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        inValid = '0;
        outReady = 4'hF;
        for (int k = 0; k < 4; k++) begin
            opS[k] = 2'd0;
            aS[k] = '0;
            bS[k] = '0;
        end
        #12;
        checkOutput("reset outValid", {44'b0, outValid}, 48'd0);
        checkOutput("reset y dut1", yBus[1], 48'd0);
        #10 rst_n = 1'b1;
        #1;
        checkOutput("inReady after reset", {44'b0, inReady}, 48'hF);
        @(posedge clk);
        #1;

        // 8x1 ADD with explicit latency check.
        inValid[0] = 1'b1; opS[0] = 2'd0; aS[0] = 48'hFF; bS[0] = 48'h10;
        @(negedge clk);
        checkOutput("latency inReady", {47'b0, inReady[0]}, 48'd1);
        pushExp(0, '{y: 48'h0F, c: 4'b0001});
        @(posedge clk);
        #1 inValid[0] = 1'b0;
        checkOutput("latency outValid after 1st edge", {47'b0, outValid[0]}, 48'd0);
        @(posedge clk);
        #1;
        checkOutput("latency outValid after 2nd edge", {47'b0, outValid[0]}, 48'd1);
        drain(0);

        // 12x4 ADD and SUB, back to back; lanes must not leak carries.
        applyStimulus(1, 2'd0, 48'hFEC_0FF_017_FFF, 48'hFF9_007_007_010, 48'hFE5_106_01E_00F, 4'b1001);
        applyStimulus(1, 2'd1, 48'h000_800_123_005, 48'h001_800_023_006, 48'hFFF_000_100_FFF, 4'b1001);
        drain(1);

        // 24x2 SUB and ADD.
        applyStimulus(2, 2'd1, {24'd1, 24'd10}, {24'd16, 24'd1}, {24'hFFFFF1, 24'h000009}, 4'b0010);
        applyStimulus(2, 2'd0, {24'hFFFFFF, 24'h123456}, {24'h000001, 24'h111111}, {24'h000000, 24'h234567}, 4'b0010);
        drain(2);

        // 12x1 accumulator chain.
        applyStimulus(3, 2'd3, 48'h123, 48'h456, 48'h000, 4'b0);
        applyStimulus(3, 2'd2, 48'h5, 48'h7, 48'h005, 4'b0);
        applyStimulus(3, 2'd2, 48'h5, 48'h0, 48'h00A, 4'b0);
        applyStimulus(3, 2'd2, 48'h5, 48'h0, 48'h00F, 4'b0);
        applyStimulus(3, 2'd2, 48'hFF1, 48'h0, 48'h000, 4'b0001);
        drain(3);
        checkOutput("acc after wrap", {36'b0, u3.acc_q}, 48'd0);

        // Backpressure: two items held, stray ACC offered while stalled.
        outReady[3] = 1'b0;
        applyStimulus(3, 2'd0, 48'h1, 48'h2, 48'h3, 4'b0);
        applyStimulus(3, 2'd0, 48'h4, 48'h5, 48'h9, 4'b0);
        inValid[3] = 1'b1; opS[3] = 2'd2; aS[3] = 48'h7;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checkOutput("stall inReady", {47'b0, inReady[3]}, 48'd0);
            checkOutput("stall outValid", {47'b0, outValid[3]}, 48'd1);
            checkOutput("stall y", yBus[3], 48'h3);
            checkOutput("stall acc", {36'b0, u3.acc_q}, 48'd0);
            @(posedge clk);
            #1;
        end
        inValid[3] = 1'b0;
        outReady[3] = 1'b1;
        drain(3);
        checkOutput("acc after stall", {36'b0, u3.acc_q}, 48'd0);

        // Reset while ACC items are in flight.
        applyStimulus(3, 2'd2, 48'h2, 48'h0, 48'h2, 4'b0);
        applyStimulus(3, 2'd2, 48'h4, 48'h0, 48'h6, 4'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset outValid", {47'b0, outValid[3]}, 48'd0);
        checkOutput("midreset acc", {36'b0, u3.acc_q}, 48'd0);
        checkOutput("midreset y", yBus[3], 48'd0);
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        #10 rst_n = 1'b1;
        #1;
        checkOutput("inReady after midreset", {47'b0, inReady[3]}, 48'd1);
        @(posedge clk);
        #1;
        applyStimulus(3, 2'd2, 48'h3, 48'h0, 48'h3, 4'b0);
        drain(3);
        checkOutput("acc after restart", {36'b0, u3.acc_q}, 48'd3);

        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("final queue dut%0d", k), 48'(qSize(k)), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_simd_alu.md
DSP_SIMD_ALU -- requirements
Module: dsp_simd_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the per-lane operand and result width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of independent SIMD lanes; legal values are 1..4 with LANES*WIDTH <= 48.
REQ-003 clock  in  1  sole clock; all state SHALL change on its rising edge, except on reset.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  the input transaction is present.
REQ-006 in_ready  out  1  the block can accept an input this cycle.
REQ-007 op  in  2  operation select: 0 ADD, 1 SUB, 2 ACC, 3 CLR.
REQ-008 a  in  LANES*WIDTH  operand A; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 b  in  LANES*WIDTH  operand B, packed the same way as a.
REQ-010 out_valid  out  1  y and carry hold a valid result.
REQ-011 out_ready  in  1  the consumer accepts the result.
REQ-012 y  out  LANES*WIDTH  per-lane result, packed the same way as a.
REQ-013 carry  out  LANES  per-lane carry or borrow flag.

Function
REQ-014 The block SHALL accept an input on a rising edge where in_valid=1 and in_ready=1.
REQ-015 The block SHALL produce an output when out_valid=1 and out_ready=1 on the same rising edge.
REQ-016 The pipeline SHALL have two stages, S1 (operand register) and S2 (result register), each with its own valid bit.
REQ-017 Stage enable en SHALL be (!S2.valid || out_ready); in_ready SHALL equal en.
REQ-018 When en=1, S1 SHALL load the inputs with valid=in_valid, and S2 SHALL load the S1 result with valid=S1.valid.
REQ-019 When en=0, S1, S2, the accumulators, y and carry SHALL all hold.
REQ-020 Latency: an input accepted at edge N with no stall SHALL give out_valid=1 after edge N+1.
REQ-021 Full throughput: one transaction per cycle SHALL be sustained while out_ready=1.
REQ-022 Each lane SHALL compute independently, modulo 2^WIDTH; no carry or borrow SHALL propagate between lanes.
REQ-023 ADD: y_i = a_i + b_i; carry_i = carry out of bit WIDTH-1.
REQ-024 SUB: y_i = a_i - b_i; carry_i = 1 iff a_i < b_i unsigned (borrow).
REQ-025 ACC: y_i = acc_i + a_i; acc_i SHALL take the same value; carry_i = carry out; b is ignored.
REQ-026 CLR: acc_i, y_i and carry_i SHALL all become 0.
REQ-027 Each lane SHALL keep a WIDTH-bit accumulator acc_i, updated only when a valid ACC or CLR transaction moves S1->S2.
REQ-028 Back-to-back ACC transactions SHALL chain, with each using the acc value written by its predecessor.
REQ-029 A bubble (S1.valid=0) moving into S2 SHALL clear out_valid, and y and carry SHALL keep their previous values.
REQ-030 Stall: while out_valid=1 and out_ready=0, no transaction SHALL be lost, duplicated or reordered.
REQ-031 Stall: in_ready SHALL be 0 while the stall lasts.
REQ-032 Operands applied while in_ready=0 SHALL be ignored and SHALL NOT affect any state.

Reset
REQ-033 When reset=0, S1.valid, S2.valid, out_valid, y, carry and every acc_i SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-034 Transactions in flight when reset asserts SHALL be discarded, and no result for them SHALL appear after release.
REQ-035 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-036 The bench SHALL cover WIDTH=8, LANES=1, ADD, a=0xFF, b=0x10 -> y=0x0F, carry=1, with out_valid high after the 2nd edge following acceptance.
REQ-037 The bench SHALL cover WIDTH=12, LANES=4, ADD, a={0xFEC,0x0FF,0x017,0xFFF}, b={0xFF9,0x007,0x007,0x010} (lane3..lane0) -> y={0xFE5,0x106,0x01E,0x00F}, carry=4'b1001, with no cross-lane carry.
REQ-038 The bench SHALL cover WIDTH=24, LANES=2, SUB, a={1,10}, b={16,1} -> y={0xFFFFF1,0x000009}, carry=2'b10.
REQ-039 The bench SHALL cover WIDTH=12, LANES=1: CLR, then ACC a=5,5,5 back-to-back -> y=5,10,15; then ACC a=0xFF1 -> y=0x000, carry=1.
REQ-040 The bench SHALL cover backpressure: two items in flight, out_ready=0 for 3 cycles -> in_ready=0, y and acc stable; after release both items emerge in order, exactly once.
REQ-041 The bench SHALL cover reset mid-stream: reset=0 asserted between edges while ACC items are in flight -> out_valid=0 and acc=0 at once; after release, ACC a=3 -> y=3.
